// File: rtl/persp_divide_seq_if.sv
// Port bundle for the perspective-divide stage: vertex input, shared-divider
// handshake and NDC result output. 'slave' is the stage, 'master' its surroundings.
interface persp_divide_seq_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [WIDTH-1:0] in_z;
  logic [WIDTH-1:0] in_w;
  logic [TAG_W-1:0] in_tag;

  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_ready;
  logic             div_valid;
  logic [WIDTH-1:0] div_quotient;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_x;
  logic [WIDTH-1:0] out_y;
  logic [WIDTH-1:0] out_z;
  logic             out_clip;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_x, in_y, in_z, in_w, in_tag,
    output in_ready,
    output div_start, div_dividend, div_divisor,
    input  div_ready, div_valid, div_quotient,
    output out_valid, out_x, out_y, out_z, out_clip, out_tag,
    input  out_ready
  );

  modport master (
    output in_valid, in_x, in_y, in_z, in_w, in_tag,
    input  in_ready,
    input  div_start, div_dividend, div_divisor,
    output div_ready, div_valid, div_quotient,
    input  out_valid, out_x, out_y, out_z, out_clip, out_tag,
    output out_ready
  );
endinterface

// File: rtl/persp_divide_seq.sv
// Perspective divide: x/w, y/w, z/w computed one after another on a single
// shared sequential divider, result presented with clip flag and tag.
module persp_divide_seq #(
  parameter int WIDTH  = 16,
  parameter int Q_BITS = 12,
  parameter int TAG_W  = 4
) (
  input logic               clk,
  input logic               reset_n,
  persp_divide_seq_if.slave bus
);

  if (Q_BITS < 0 || Q_BITS >= WIDTH) begin : g_bad_q_bits
    $error("persp_divide_seq: Q_BITS must lie in [0, WIDTH-1]");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic [WIDTH-1:0] res_x;
  logic [WIDTH-1:0] res_y;
  logic             clip_q;
  logic [TAG_W-1:0] tag_q;

  // NOTE: these are plain continuous decodes of registered state, so no latch
  // can form; the start pulse lands in the very cycle the divider reports idle.
  assign bus.in_ready  = (state == IDLE);
  assign bus.div_start = (state == ISSUE) && bus.div_ready;

  // NOTE: every register here uses non-blocking assignment so all updates in a
  // cycle see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      idx              <= 2'd0;
      y_q              <= '0;
      z_q              <= '0;
      res_x            <= '0;
      res_y            <= '0;
      clip_q           <= 1'b0;
      tag_q            <= '0;
      bus.div_dividend <= '0;
      bus.div_divisor  <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_x        <= '0;
      bus.out_y        <= '0;
      bus.out_z        <= '0;
      bus.out_clip     <= 1'b0;
      bus.out_tag      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            y_q              <= bus.in_y;
            z_q              <= bus.in_z;
            tag_q            <= bus.in_tag;
            clip_q           <= bus.in_w[WIDTH-1] | (bus.in_w == '0);
            idx              <= 2'd0;
            // Divider samples its operands live, so they are set up here and
            // held untouched until the matching quotient has been captured.
            bus.div_dividend <= bus.in_x;
            bus.div_divisor  <= bus.in_w;
            state            <= ISSUE;
          end
        end

        ISSUE: begin
          if (bus.div_ready) state <= WAIT;
        end

        WAIT: begin
          if (bus.div_valid) begin
            if (idx == 2'd2) begin
              bus.out_x     <= res_x;
              bus.out_y     <= res_y;
              bus.out_z     <= bus.div_quotient;
              bus.out_clip  <= clip_q;
              bus.out_tag   <= tag_q;
              bus.out_valid <= 1'b1;
              state         <= OUTPUT;
            end else begin
              if (idx == 2'd0) begin
                res_x            <= bus.div_quotient;
                bus.div_dividend <= y_q;
              end else begin
                res_y            <= bus.div_quotient;
                bus.div_dividend <= z_q;
              end
              idx   <= idx + 2'd1;
              state <= ISSUE;
            end
          end
        end

        OUTPUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_persp_divide_seq.sv
// Directed bench for persp_divide_seq with a behavioural sequential divider.
module tb_persp_divide_seq;
  localparam int WIDTH   = 16;
  localparam int Q_BITS  = 12;
  localparam int TAG_W   = 4;
  localparam int DIV_LAT = 4;
  localparam int TIMEOUT = 500;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  persp_divide_seq_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  persp_divide_seq #(.WIDTH(WIDTH), .Q_BITS(Q_BITS), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural divider: Q-format signed divide with saturation, result formed
  // from whatever operands are on the bus when it completes.
  function automatic logic [WIDTH-1:0] div_model(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    longint nn, dd, q;
    nn = longint'($signed(n)) <<< Q_BITS;
    dd = longint'($signed(d));
    if (dd == 0) return n[WIDTH-1] ? 16'h8000 : 16'h7FFF;
    q = nn / dd;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[WIDTH-1:0];
  endfunction

  logic             ready_en;
  logic             mdl_busy;
  int               mdl_cnt;
  logic             mdl_valid;
  logic [WIDTH-1:0] mdl_q;
  logic             inj_valid;
  logic [WIDTH-1:0] inj_q;

  assign bus.div_ready    = ~mdl_busy & ~mdl_valid & ready_en;
  assign bus.div_valid    = mdl_valid | inj_valid;
  assign bus.div_quotient = inj_valid ? inj_q : mdl_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy  <= 1'b0;
      mdl_cnt   <= 0;
      mdl_valid <= 1'b0;
      mdl_q     <= '0;
    end else begin
      mdl_valid <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 1) begin
          mdl_busy  <= 1'b0;
          mdl_valid <= 1'b1;
          mdl_q     <= div_model(bus.div_dividend, bus.div_divisor);
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end else if (bus.div_start && bus.div_ready) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= DIV_LAT;
      end
    end
  end

  int starts = 0;
  always @(posedge clk) if (bus.div_start) starts <= starts + 1;

  // Operands must not move between a start pulse and its quotient.
  logic             trk;
  logic [WIDTH-1:0] hold_n, hold_d;
  int               op_err = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      trk <= 1'b0;
    end else if (bus.div_start) begin
      hold_n <= bus.div_dividend;
      hold_d <= bus.div_divisor;
      trk    <= 1'b1;
    end else if (trk) begin
      if (bus.div_dividend !== hold_n || bus.div_divisor !== hold_d) op_err <= op_err + 1;
      if (bus.div_valid) trk <= 1'b0;
    end
  end

  typedef struct {
    logic [WIDTH-1:0] x, y, z, w;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] ex, ey, ez;
    logic             eclip;
  } vec_t;

  vec_t vecs [6];

  task automatic send_vec(input vec_t v, input string nm);
    check({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_x     = v.x;
    bus.in_y     = v.y;
    bus.in_z     = v.z;
    bus.in_w     = v.w;
    bus.in_tag   = v.tag;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_vec(input vec_t v, input string nm, input int s0);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({nm, "_out_x"}, {16'd0, bus.out_x}, {16'd0, v.ex});
    check({nm, "_out_y"}, {16'd0, bus.out_y}, {16'd0, v.ey});
    check({nm, "_out_z"}, {16'd0, bus.out_z}, {16'd0, v.ez});
    check({nm, "_out_clip"}, {31'd0, bus.out_clip}, {31'd0, v.eclip});
    check({nm, "_out_tag"}, {28'd0, bus.out_tag}, {28'd0, v.tag});
    check({nm, "_start_pulses"}, starts - s0, 32'd3);
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int s0;
    s0 = starts;
    send_vec(v, nm);
    finish_vec(v, nm, s0);
  endtask

  initial begin
    int s0, n;
    vecs[0] = '{x:16'h1000, y:16'h0800, z:16'hF000, w:16'h2000, tag:4'h3,
                ex:16'h0800, ey:16'h0400, ez:16'hF800, eclip:1'b0};
    vecs[1] = '{x:16'h1000, y:16'h0000, z:16'h2000, w:16'hE000, tag:4'h5,
                ex:16'hF800, ey:16'h0000, ez:16'hF000, eclip:1'b1};
    vecs[2] = '{x:16'h1000, y:16'h0000, z:16'hF000, w:16'h0000, tag:4'h9,
                ex:16'h7FFF, ey:16'h7FFF, ez:16'h8000, eclip:1'b1};
    vecs[3] = '{x:16'h0600, y:16'hFA00, z:16'h0C00, w:16'h3000, tag:4'hF,
                ex:16'h0200, ey:16'hFE00, ez:16'h0400, eclip:1'b0};
    vecs[4] = '{x:16'h7000, y:16'h8000, z:16'h0001, w:16'h1000, tag:4'h0,
                ex:16'h7000, ey:16'h8000, ez:16'h0001, eclip:1'b0};
    vecs[5] = '{x:16'h2000, y:16'hE000, z:16'h0000, w:16'h0800, tag:4'h6,
                ex:16'h4000, ey:16'hC000, ez:16'h0000, eclip:1'b0};

    rst_n         = 1'b0;
    ready_en      = 1'b1;
    inj_valid     = 1'b0;
    inj_q         = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.in_w      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    #13;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_div_start", {31'd0, bus.div_start}, 32'd0);
    check("rst_div_dividend", {16'd0, bus.div_dividend}, 32'd0);
    check("rst_div_divisor", {16'd0, bus.div_divisor}, 32'd0);
    check("rst_out_xyz", {bus.out_x, bus.out_y | bus.out_z}, 32'd0);
    check("rst_out_clip_tag", {27'd0, bus.out_clip, bus.out_tag}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Divider busy elsewhere for 7 cycles after accept.
    ready_en = 1'b0;
    s0 = starts;
    send_vec(vecs[0], "stall_div");
    repeat (7) begin
      @(negedge clk);
      check("stall_div_start_low", {31'd0, bus.div_start}, 32'd0);
    end
    @(posedge clk); #1;
    check("stall_div_no_starts", starts - s0, 32'd0);
    check("stall_div_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("stall_div_dividend", {16'd0, bus.div_dividend}, 32'h1000);
    check("stall_div_divisor", {16'd0, bus.div_divisor}, 32'h2000);
    ready_en = 1'b1;
    #1;
    check("stall_div_first_pulse", {31'd0, bus.div_start}, 32'd1);
    finish_vec(vecs[0], "stall_div", s0);

    // Downstream back-pressure for 5 cycles with the result held.
    bus.out_ready = 1'b0;
    s0 = starts;
    send_vec(vecs[3], "stall_out");
    finish_vec(vecs[3], "stall_out", s0);
    repeat (5) begin
      @(negedge clk);
      check("stall_out_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_out_hold_xyz", {bus.out_x, bus.out_z}, {vecs[3].ex, vecs[3].ez});
      check("stall_out_hold_y", {16'd0, bus.out_y}, {16'd0, vecs[3].ey});
      check("stall_out_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_out_no_start", {31'd0, bus.div_start}, 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_out_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("stall_out_release_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset while the y quotient is outstanding.
    s0 = starts;
    send_vec(vecs[0], "mid_reset");
    n = 0;
    while (starts - s0 < 2 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_reached_y", starts - s0, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_reset_dividend", {16'd0, bus.div_dividend}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    inj_q     = 16'h1234;
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    check("late_valid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("late_valid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("late_valid_no_start", {31'd0, bus.div_start}, 32'd0);
    @(posedge clk); #1;
    run_vec(vecs[4], "post_reset");

    check("operand_hold_violations", op_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
